uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver. It is the next-generation receive path for the serial link and sits between the baud-rate generator (`s_tick`) and the byte consumer. It adds the following over the first-generation receiver:
- configurable data width, oversampling ratio, parity and stop-bit count;
- input synchronisation and false-start rejection;
- framing, parity and overrun error reporting;
- a valid/ready holding register in place of a single-cycle `dout` pulse.

Parameters:
- `DBIT`, 8: data bits per frame; legal range 5..9.
- `OVS`, 16: `s_tick`s per bit period; even, at least 8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `s_tick`, in, 1: oversample enable from the baud generator; one `clk` wide.
- `rx`, in, 1: asynchronous serial line; idles high.
- `dout`, out, DBIT: received word, LSB = first bit on the line.
- `rx_valid`, out, 1: `dout` and the error flags hold a word.
- `rx_ready`, in, 1: consumer accepts the word.
- `parity_err`, out, 1: parity mismatch on the held word.
- `frame_err`, out, 1: a stop bit sampled 0 on the held word.
- `overrun`, out, 1: one or more words were dropped while `rx_valid` was high.
- `busy`, out, 1: FSM is not in IDLE.

Behaviour:
- **Clock and reset.** One clock; reset is synchronous and active-high. Port names are `clk` and `reset`.
- **Reset values.** `dout`=0, `rx_valid`=0, all error flags 0, `busy`=0, FSM=IDLE, counters=0. Synchroniser flops reset to 1.
- **Reset mid-frame.** Abandons the frame; nothing is delivered.
- **Synchroniser.** `rx` passes through 2 flops to give `rx_s`. All decisions use `rx_s`.
- **Tick gating.** The FSM and counters advance only on cycles with `s_tick`=1. The handshake logic runs every `clk`.
- **Counters.**
  - `s`: `$clog2(OVS)` bits, counts ticks within a bit.
  - `n`: `$clog2(DBIT)` bits, counts data bits.
  - Shift register: DBIT wide. Each data bit enters at the MSB and the register shifts right.
- **IDLE.** `rx_s`=0 → START, `s`=0.
- **START.**
  - At `s`=OVS/2-1: `rx_s`=1 → IDLE (glitch rejected); else `s`=0 → DATA.
  - Otherwise `s`++.
- **DATA.**
  - At `s`=OVS-1: sample, shift, `s`=0.
  - If `n`=DBIT-1: go to PARITY when PARITY≠0, else STOP. Otherwise `n`++.
- **PARITY.** At `s`=OVS-1: sample and compare against the XOR of the data bits.
  - Odd mode: the total count of 1s including the parity bit must be odd.
  - Go to STOP.
- **STOP.**
  - At `s`=OVS-1: a sample of 0 sets the frame-error latch.
  - After STOP_BITS stop bits → DELIVER. All stop bits are checked.
- **DELIVER** (single `clk`, tick-independent). Loads the holding register, then goes to IDLE.
  - If the frame error latch is set and `rx_s`=0, go to BREAK instead.
- **BREAK.** Wait for `rx_s`=1, then → IDLE. A break therefore produces exactly one word: `dout`=0 with `frame_err`=1.
- **Holding register.**
  - Handshake occurs when `rx_valid`&&`rx_ready` on the same `clk`. It clears `rx_valid`, `parity_err`, `frame_err` and `overrun` next cycle.
  - DELIVER with `rx_valid`=0, or with a handshake in the same cycle: load `dout` and the flags, `rx_valid`=1.
  - DELIVER with `rx_valid`=1 and no handshake: keep the old word, set `overrun`=1, discard the new word.
  - `rx_valid` rises 1 `clk` after the tick that samples the last stop bit.
- **Error flag validity.** Error flags are meaningful only while `rx_valid`=1.

Optional Feature:
- Macro: `UART_RX_MAJORITY_EN`.
- Defined: every bit (start check, data, parity, stop) is the 2-of-3 majority of the `rx_s` samples at ticks C-2, C-1 and C, where C is the nominal sample tick.
- Undefined: a single sample at C.
- Frame timing is identical in both builds.

Decomposition:
- Package `uart_pkg` holds:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK;
  - parity-mode constants: `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
- Sub-module `uart_rx_sync`: 2-flop synchroniser with a reset value parameter. Reused later by the transmitter's CTS input.

Test Plan:
- **Basic word, no parity.** DBIT=8, PARITY=0, OVS=16, `s_tick` every 4 `clk`; send 0xA5 with `rx_ready`=1 → `dout`=0xA5, `rx_valid` high for 1 cycle, all errors 0.
- **Parity.** PARITY=2 (even); send 0x07 with parity bit 1 → `parity_err`=0. Send 0x07 with parity bit 0 → `parity_err`=1, `dout`=0x07.
- **Glitch and framing error.**
  - A 3-tick low glitch on idle `rx` → no word delivered, `busy` returns to 0.
  - A frame with stop bit 0 → `frame_err`=1.
  - `rx` held low for 20 bit times → exactly one word, 0x00 with `frame_err`, then BREAK until `rx` rises.
- **Overrun.** `rx_ready`=0; send 0x11 then 0x22 → `dout`=0x11, `overrun`=1. Raise `rx_ready` for 1 `clk` → `rx_valid`=0, `overrun`=0.
- **Simultaneous events and reset.**
  - `rx_ready` pulsed on the exact DELIVER cycle of 0x33 while 0x11 is held → 0x33 loaded, `overrun`=0.
  - `reset` asserted mid-DATA → outputs go to reset values, and the next clean frame 0x5A is received correctly.
- **Majority sampling.** DBIT=7, STOP_BITS=2, `UART_RX_MAJORITY_EN` defined; inject a one-tick inverted spike at a data-bit centre → word still correct. The same stimulus without the macro shows the corrupted bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM states,
// parity-mode codes and a 2-of-3 majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DELIVER,
    BREAK
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Ports: clk, reset (sync, high), d (async in), q (synced out).
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with valid/ready holding register.
// Ports: clk, reset, s_tick, rx in; dout, rx_valid, rx_ready (in),
// parity_err, frame_err, overrun, busy out.
// Macro UART_RX_MAJORITY_EN: 2-of-3 majority bit sampling.
module uart_rx_param #(
  parameter int DBIT      = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);

  import uart_pkg::*;

  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);
  localparam logic [NW-1:0] N_DLAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_SLAST = NW'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == PAR_ODD);

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] sh;
  logic            perr_l;
  logic            ferr_l;
  logic            rx_s;
  logic            smp;
  logic            hs;

  uart_rx_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // rx_s at the two ticks preceding the current one
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (s_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign smp = maj3(hist[1], hist[0], rx_s);
`else
  assign smp = rx_s;
`endif

  assign hs   = rx_valid & rx_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s          <= '0;
      n          <= '0;
      sh         <= '0;
      perr_l     <= 1'b0;
      ferr_l     <= 1'b0;
      dout       <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (hs) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (s_tick && !rx_s) begin
            state  <= START;
            s      <= '0;
            n      <= '0;
            perr_l <= 1'b0;
            ferr_l <= 1'b0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              state <= smp ? IDLE : DATA;
              s     <= '0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_END) begin
              s  <= '0;
              sh <= {smp, sh[DBIT-1:1]};
              if (n == N_DLAST) begin
                n     <= '0;
                state <= (PARITY != PAR_NONE) ?
                         uart_pkg::PARITY : STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (s_tick) begin
            if (s == S_END) begin
              s      <= '0;
              perr_l <= ((^sh) ^ smp) != ODD;
              state  <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_END) begin
              s <= '0;
              if (!smp) ferr_l <= 1'b1;
              if (n == N_SLAST) begin
                n     <= '0;
                state <= DELIVER;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DELIVER: begin
          // a handshake this cycle frees the register for the new word
          if (!rx_valid || hs) begin
            dout       <= sh;
            parity_err <= perr_l;
            frame_err  <= ferr_l;
            overrun    <= 1'b0;
            rx_valid   <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= (ferr_l && !rx_s) ? BREAK : IDLE;
        end
        BREAK: begin
          if (s_tick && rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations,
// tick-accurate frame driver and an expected-word queue.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic [2:0] rx_l = 3'b111;
  logic [2:0] rdy = 3'b000;

  wire [7:0] d0;
  wire [7:0] d1;
  wire [6:0] d2;
  wire [2:0] v;
  wire [2:0] pe;
  wire [2:0] fe;
  wire [2:0] ov;
  wire [2:0] bz;

  int checks = 0;
  int failures = 0;
  int cur = 0;
  logic drv_done = 1'b0;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];

`ifdef UART_RX_MAJORITY_EN
  localparam logic [8:0] MAJ_EXP = 9'h055;
`else
  localparam logic [8:0] MAJ_EXP = 9'h051;
`endif

  uart_rx_param #(
    .DBIT(8), .OVS(16), .PARITY(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_l[0]),
    .dout(d0), .rx_valid(v[0]), .rx_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun(ov[0]), .busy(bz[0])
  );

  uart_rx_param #(
    .DBIT(8), .OVS(16), .PARITY(2), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_l[1]),
    .dout(d1), .rx_valid(v[1]), .rx_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun(ov[1]), .busy(bz[1])
  );

  uart_rx_param #(
    .DBIT(7), .OVS(16), .PARITY(0), .STOP_BITS(2)
  ) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_l[2]),
    .dout(d2), .rx_valid(v[2]), .rx_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun(ov[2]), .busy(bz[2])
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  logic [8:0] m_d;
  logic m_v, m_pe, m_fe, m_ov, m_bz;

  always_comb begin
    m_d  = {1'b0, d0};
    m_v  = v[0];
    m_pe = pe[0];
    m_fe = fe[0];
    m_ov = ov[0];
    m_bz = bz[0];
    case (cur)
      1: begin
        m_d = {1'b0, d1}; m_v = v[1]; m_pe = pe[1];
        m_fe = fe[1]; m_ov = ov[1]; m_bz = bz[1];
      end
      2: begin
        m_d = {2'b00, d2}; m_v = v[2]; m_pe = pe[2];
        m_fe = fe[2]; m_ov = ov[2]; m_bz = bz[2];
      end
      default: ;
    endcase
  end

  task automatic tick_rx(input int sel, input logic val);
    @(posedge clk);
    while (!s_tick) @(posedge clk);
    #1;
    rx_l[sel] = val;
  endtask

  // spike: frame bit inverted for one tick at its centre
  // pulse_at: tick index after which rx_ready pulses for one clk
  // max_ticks: abandon the frame after this many ticks
  task automatic send_frame(
    input int sel, input logic [8:0] data, input int dbit,
    input int npar, input logic pbit, input int nstop,
    input logic [1:0] stopv, input int spike,
    input int pulse_at, input int max_ticks
  );
    logic [15:0] fb;
    int nb;
    int j;
    logic val;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < dbit; i++) fb[1+i] = data[i];
    nb = 1 + dbit;
    if (npar != 0) begin
      fb[nb] = pbit;
      nb++;
    end
    for (int k = 0; k < nstop; k++) begin
      fb[nb] = stopv[k];
      nb++;
    end
    j = 0;
    for (int f = 0; f < nb; f++) begin
      for (int k = 0; k < 16; k++) begin
        if (max_ticks >= 0 && j >= max_ticks) break;
        val = fb[f];
        if (f == spike && k == 8) val = ~val;
        tick_rx(sel, val);
        if (j == pulse_at) begin
          rdy[sel] = 1'b1;
          @(posedge clk);
          #1;
          rdy[sel] = 1'b0;
        end
        j++;
      end
    end
    tick_rx(sel, 1'b1);
  endtask

  task automatic get_word(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (m_v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({d0, v, pe, fe, ov, bz} !== '0) begin
      failures++;
      $display("FAIL reset_state got d0=%h v=%b pe=%b fe=%b ov=%b bz=%b want 0",
               d0, v, pe, fe, ov, bz);
    end
    checks++;
    if ({d1, d2} !== '0) begin
      failures++;
      $display("FAIL reset_dout got d1=%h d2=%h want 0", d1, d2);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e;
    logic ok;
    cur = 0;
    rdy[0] = 1'b1;
    sb.push_back('{d: 9'h0A5, pe: 1'b0, fe: 1'b0});
    fork
      send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, -1, -1, -1);
      begin
        get_word(ok);
        e = sb.pop_front();
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL basic_timeout rx_valid never rose");
        end else begin
          checks++;
          if ({m_d, m_pe, m_fe, m_ov} !== {e.d, e.pe, e.fe, 1'b0}) begin
            failures++;
            $display("FAIL basic_word got %h/%b%b%b want %h/%b%b0",
                     m_d, m_pe, m_fe, m_ov, e.d, e.pe, e.fe);
          end
          @(posedge clk);
          #1;
          checks++;
          if (m_v !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse rx_valid got %b want 0", m_v);
          end
        end
      end
    join
  endtask

  task automatic test_parity();
    exp_t e;
    logic ok;
    cur = 1;
    rdy[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      sb.push_back('{d: 9'h007, pe: (t == 1), fe: 1'b0});
      fork
        send_frame(1, 9'h007, 8, 1, (t == 0), 1, 2'b11, -1, -1, -1);
        begin
          get_word(ok);
          e = sb.pop_front();
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL parity_timeout case %0d", t);
          end else if ({m_d, m_pe, m_fe} !== {e.d, e.pe, e.fe}) begin
            failures++;
            $display("FAIL parity_word case %0d got %h/%b%b want %h/%b%b",
                     t, m_d, m_pe, m_fe, e.d, e.pe, e.fe);
          end
        end
      join
    end
  endtask

  task automatic test_glitch();
    logic saw_busy;
    logic saw_valid;
    cur = 0;
    rdy[0] = 1'b1;
    saw_busy = 1'b0;
    saw_valid = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) tick_rx(0, 1'b0);
        for (int k = 0; k < 30; k++) tick_rx(0, 1'b1);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          if (m_bz) saw_busy = 1'b1;
          if (m_v) saw_valid = 1'b1;
        end
      end
    join
    checks++;
    if (saw_busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_start busy got 0 want 1");
    end
    checks++;
    if (saw_valid !== 1'b0 || m_bz !== 1'b0) begin
      failures++;
      $display("FAIL glitch_reject got valid=%b busy=%b want 0/0",
               saw_valid, m_bz);
    end
  endtask

  task automatic test_frame_err();
    exp_t e;
    logic ok;
    cur = 0;
    rdy[0] = 1'b1;
    sb.push_back('{d: 9'h03C, pe: 1'b0, fe: 1'b1});
    fork
      send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b00, -1, -1, -1);
      begin
        get_word(ok);
        e = sb.pop_front();
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL frame_timeout no word");
        end else if ({m_d, m_pe, m_fe} !== {e.d, e.pe, e.fe}) begin
          failures++;
          $display("FAIL frame_word got %h/%b%b want %h/%b%b",
                   m_d, m_pe, m_fe, e.d, e.pe, e.fe);
        end
      end
    join
    repeat (4) tick_rx(0, 1'b1);
  endtask

  task automatic test_break();
    exp_t e;
    logic ok;
    int extra;
    cur = 0;
    rdy[0] = 1'b1;
    extra = 0;
    drv_done = 1'b0;
    sb.push_back('{d: 9'h000, pe: 1'b0, fe: 1'b1});
    fork
      begin
        for (int k = 0; k < 320; k++) tick_rx(0, 1'b0);
        drv_done = 1'b1;
      end
      begin
        get_word(ok);
        e = sb.pop_front();
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL break_timeout no word");
        end else if ({m_d, m_pe, m_fe} !== {e.d, e.pe, e.fe}) begin
          failures++;
          $display("FAIL break_word got %h/%b%b want %h/%b%b",
                   m_d, m_pe, m_fe, e.d, e.pe, e.fe);
        end
        while (!drv_done) begin
          @(posedge clk);
          #1;
          if (m_v) extra++;
        end
      end
    join
    checks++;
    if (extra != 0 || m_bz !== 1'b1) begin
      failures++;
      $display("FAIL break_hold got extra=%0d busy=%b want 0/1",
               extra, m_bz);
    end
    repeat (4) tick_rx(0, 1'b1);
    checks++;
    if (m_bz !== 1'b0) begin
      failures++;
      $display("FAIL break_exit busy got %b want 0", m_bz);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    logic ok;
    cur = 0;
    rdy[0] = 1'b0;
    sb.push_back('{d: 9'h011, pe: 1'b0, fe: 1'b0});
    fork
      send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, -1, -1, -1);
      begin
        get_word(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || {m_d, m_ov} !== {e.d, 1'b0}) begin
          failures++;
          $display("FAIL ovr_first got ok=%b %h ov=%b want 1 %h ov=0",
                   ok, m_d, m_ov, e.d);
        end
      end
    join
    fork
      send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, -1, -1, -1);
      begin
        for (int i = 0; i < 3000; i++) begin
          @(posedge clk);
          #1;
          if (m_ov) break;
        end
      end
    join
    checks++;
    if ({m_v, m_ov, m_d} !== {1'b1, 1'b1, 9'h011}) begin
      failures++;
      $display("FAIL ovr_hold got v=%b ov=%b d=%h want 1 1 011",
               m_v, m_ov, m_d);
    end
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    checks++;
    if ({m_v, m_ov} !== 2'b00) begin
      failures++;
      $display("FAIL ovr_clear got v=%b ov=%b want 0 0", m_v, m_ov);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic ok;
    cur = 0;
    rdy[0] = 1'b0;
    sb.push_back('{d: 9'h011, pe: 1'b0, fe: 1'b0});
    fork
      send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, -1, -1, -1);
      begin
        get_word(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || m_d !== e.d) begin
          failures++;
          $display("FAIL simul_first got ok=%b %h want 1 %h", ok, m_d, e.d);
        end
      end
    join
    sb.push_back('{d: 9'h033, pe: 1'b0, fe: 1'b0});
    // last stop bit sampled at tick 9+16*9; DELIVER follows it
    send_frame(0, 9'h033, 8, 0, 1'b0, 1, 2'b11, -1, 153, -1);
    e = sb.pop_front();
    checks++;
    if ({m_v, m_ov, m_d, m_fe} !== {1'b1, 1'b0, e.d, e.fe}) begin
      failures++;
      $display("FAIL simul_load got v=%b ov=%b d=%h want 1 0 %h",
               m_v, m_ov, m_d, e.d);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic ok;
    cur = 0;
    send_frame(0, 9'h0C3, 8, 0, 1'b0, 1, 2'b11, -1, -1, 48);
    checks++;
    if (m_bz !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy got %b want 1", m_bz);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({m_d, m_v, m_pe, m_fe, m_ov, m_bz} !== '0) begin
      failures++;
      $display("FAIL rstmid_state got d=%h v=%b pe=%b fe=%b ov=%b bz=%b want 0",
               m_d, m_v, m_pe, m_fe, m_ov, m_bz);
    end
    repeat (4) tick_rx(0, 1'b1);
    rdy[0] = 1'b1;
    sb.push_back('{d: 9'h05A, pe: 1'b0, fe: 1'b0});
    fork
      send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11, -1, -1, -1);
      begin
        get_word(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || {m_d, m_pe, m_fe} !== {e.d, e.pe, e.fe}) begin
          failures++;
          $display("FAIL rstmid_word got ok=%b %h/%b%b want %h/%b%b",
                   ok, m_d, m_pe, m_fe, e.d, e.pe, e.fe);
        end
      end
    join
  endtask

  task automatic test_majority();
    exp_t e;
    logic ok;
    cur = 2;
    rdy[2] = 1'b1;
    sb.push_back('{d: MAJ_EXP, pe: 1'b0, fe: 1'b0});
    sb.push_back('{d: 9'h02A, pe: 1'b0, fe: 1'b1});
    fork
      send_frame(2, 9'h055, 7, 0, 1'b0, 2, 2'b11, 3, -1, -1);
      begin
        get_word(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || {m_d, m_pe, m_fe} !== {e.d, e.pe, e.fe}) begin
          failures++;
          $display("FAIL maj_spike got ok=%b %h/%b%b want %h/%b%b",
                   ok, m_d, m_pe, m_fe, e.d, e.pe, e.fe);
        end
      end
    join
    fork
      send_frame(2, 9'h02A, 7, 0, 1'b0, 2, 2'b01, -1, -1, -1);
      begin
        get_word(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || {m_d, m_pe, m_fe} !== {e.d, e.pe, e.fe}) begin
          failures++;
          $display("FAIL stop2_err got ok=%b %h/%b%b want %h/%b%b",
                   ok, m_d, m_pe, m_fe, e.d, e.pe, e.fe);
        end
      end
    join
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    repeat (4) tick_rx(0, 1'b1);
    test_basic();
    test_parity();
    test_glitch();
    test_frame_err();
    test_break();
    test_overrun();
    test_simultaneous();
    test_reset_mid();
    test_majority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
